// File: rtl/hall_pattern_generator_if.sv
// Command/status bundle for the hall pattern generator.
//   master : drives enable, direction, period_in, period_load;
//            observes hall, step_index, step_pulse, rev_pulse.
//   slave  : the generator side of the same signals.
interface hall_pattern_generator_if #(
  parameter int PERIOD_W = 11
);
  logic                enable;
  logic                direction;
  logic [PERIOD_W-1:0] period_in;
  logic                period_load;
  logic [2:0]          hall;
  logic [2:0]          step_index;
  logic                step_pulse;
  logic                rev_pulse;

  modport master (
    output enable, direction, period_in, period_load,
    input  hall, step_index, step_pulse, rev_pulse
  );

  modport slave (
    input  enable, direction, period_in, period_load,
    output hall, step_index, step_pulse, rev_pulse
  );
endinterface

// File: rtl/hall_pattern_generator.sv
// Hall-sensor emulator: steps through the 6-step 120-degree commutation
// code (101,100,110,010,011,001) at a commanded period measured in
// PRESCALE-clock ticks, forward or reverse.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : slave side of hall_pattern_generator_if
//            (enable, direction, period_in, period_load in;
//             hall, step_index, step_pulse, rev_pulse out)
module hall_pattern_generator #(
  parameter int PERIOD_W   = 11,
  parameter int PRESCALE   = 435,
  parameter int MIN_PERIOD = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  hall_pattern_generator_if.slave  bus
);

  localparam int                  PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]     PS_ZERO = PS_W'(0);
  localparam logic [PS_W-1:0]     PS_ONE  = PS_W'(1);
  localparam logic [PERIOD_W-1:0] P_ZERO  = PERIOD_W'(0);
  localparam logic [PERIOD_W-1:0] P_ONE   = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] P_MIN   = PERIOD_W'(MIN_PERIOD);

  // Zero means stop; very short non-zero periods are raised to the minimum.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    logic [PERIOD_W-1:0] r;
    if (p == P_ZERO) begin
      r = P_ZERO;
    end else if (p < P_MIN) begin
      r = P_MIN;
    end else begin
      r = p;
    end
    return r;
  endfunction

  // Index-to-code table; out-of-range indices map to a legal code.
  function automatic logic [2:0] hall_decode(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b101;
      3'd1:    code = 3'b100;
      3'd2:    code = 3'b110;
      3'd3:    code = 3'b010;
      3'd4:    code = 3'b011;
      3'd5:    code = 3'b001;
      default: code = 3'b101;
    endcase
    return code;
  endfunction

  logic [PS_W-1:0]     prescale_r;
  logic [PERIOD_W-1:0] count_r;
  logic [PERIOD_W-1:0] active_period_r;
  logic [PERIOD_W-1:0] pending_period_r;
  logic [2:0]          step_index_r;
  logic [2:0]          hall_r;
  logic                step_pulse_r;
  logic                rev_pulse_r;

  logic                counting_s;
  logic                tick_s;
  logic                step_s;
  logic                wrap_s;
  logic [2:0]          next_index_s;
  logic [PERIOD_W-1:0] load_clamp_s;

  // Tick/step detection and next index in the sampled direction.
  always_comb begin
    counting_s   = bus.enable && (active_period_r != P_ZERO);
    tick_s       = counting_s && (prescale_r == PS_LAST);
    step_s       = tick_s && (count_r == (active_period_r - P_ONE));
    load_clamp_s = clamp_period(bus.period_in);
    if (bus.direction) begin
      wrap_s       = (step_index_r == 3'd5);
      next_index_s = wrap_s ? 3'd0 : (step_index_r + 3'd1);
    end else begin
      wrap_s       = (step_index_r == 3'd0);
      next_index_s = wrap_s ? 3'd5 : (step_index_r - 3'd1);
    end
  end

  // Prescaler, tick counter, period registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescale_r       <= PS_ZERO;
      count_r          <= P_ZERO;
      active_period_r  <= P_ZERO;
      pending_period_r <= P_ZERO;
      step_index_r     <= 3'd0;
      hall_r           <= 3'b101;
      step_pulse_r     <= 1'b0;
      rev_pulse_r      <= 1'b0;
    end else begin
      step_pulse_r <= step_s;
      rev_pulse_r  <= step_s && wrap_s;
      if (step_s) begin
        step_index_r <= next_index_s;
        hall_r       <= hall_decode(next_index_s);
        prescale_r   <= PS_ZERO;
        count_r      <= P_ZERO;
        // A load landing on the step cycle takes effect for the very next step.
        if (bus.period_load) begin
          active_period_r  <= load_clamp_s;
          pending_period_r <= load_clamp_s;
        end else begin
          active_period_r  <= pending_period_r;
        end
      end else if (bus.period_load && (active_period_r == P_ZERO)) begin
        // Starting from stop: restart timing from the load cycle.
        if (load_clamp_s != P_ZERO) begin
          active_period_r  <= load_clamp_s;
          pending_period_r <= load_clamp_s;
          prescale_r       <= PS_ZERO;
          count_r          <= P_ZERO;
        end else begin
          pending_period_r <= P_ZERO;
        end
      end else begin
        // While running, a new period waits for the current step to finish.
        if (bus.period_load) begin
          pending_period_r <= load_clamp_s;
        end else begin
          pending_period_r <= pending_period_r;
        end
        if (tick_s) begin
          prescale_r <= PS_ZERO;
          count_r    <= count_r + P_ONE;
        end else if (counting_s) begin
          prescale_r <= prescale_r + PS_ONE;
        end else begin
          prescale_r <= prescale_r;
        end
      end
    end
  end

  assign bus.hall       = hall_r;
  assign bus.step_index = step_index_r;
  assign bus.step_pulse = step_pulse_r;
  assign bus.rev_pulse  = rev_pulse_r;

endmodule

// File: tb/tb_hall_pattern_generator.sv
module tb_hall_pattern_generator;

  logic clock;
  logic reset;
  int   cyc;
  int   n_pass;
  int   n_total;

  hall_pattern_generator_if #(.PERIOD_W(11)) bus ();

  hall_pattern_generator #(
    .PERIOD_W  (11),
    .PRESCALE  (4),
    .MIN_PERIOD(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int         cyc;
    logic [2:0] hall;
    logic [2:0] idx;
    logic       rev;
  } exp_t;

  exp_t q[$];
  exp_t e;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic push(input int c, input logic [2:0] h, input logic [2:0] i, input logic r);
    exp_t x;
    x.cyc = c; x.hall = h; x.idx = i; x.rev = r;
    q.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  // Drive a one-cycle load; returns the cycle number of the sampling edge.
  task automatic do_load(input int p, output int edge_c);
    bus.period_in   = 11'(p);
    bus.period_load = 1'b1;
    @(negedge clock);
    bus.period_load = 1'b0;
    edge_c = cyc;
  endtask

  // Monitor: every step_pulse must match the head of the expectation queue.
  always @(negedge clock) begin
    if (bus.step_pulse) begin
      if (q.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        e = q.pop_front();
        check("step_time", cyc, e.cyc);
        check("hall", bus.hall, e.hall);
        check("step_index", bus.step_index, e.idx);
        check("rev_pulse", bus.rev_pulse, e.rev);
      end
    end else begin
      if (bus.rev_pulse) check("rev_without_step", 1, 0);
      if (q.size() > 0 && cyc > q[0].cyc) begin
        check("step_time", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  int b, c, d, t;

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0;
    bus.enable = 1'b0; bus.direction = 1'b1;
    bus.period_in = 11'd0; bus.period_load = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_hall", bus.hall, 3'b101);
    check("rst_index", bus.step_index, 3'd0);
    check("rst_step_pulse", bus.step_pulse, 1'b0);
    check("rst_rev_pulse", bus.rev_pulse, 1'b0);
    reset = 1'b1;
    bus.enable = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_hall", bus.hall, 3'b101);
    check("idle_index", bus.step_index, 3'd0);

    // 1: start from stop at P=3, forward
    do_load(3, b);
    push(b+12, 3'b100, 3'd1, 1'b0);
    push(b+24, 3'b110, 3'd2, 1'b0);
    push(b+36, 3'b010, 3'd3, 1'b0);
    push(b+48, 3'b011, 3'd4, 1'b0);
    push(b+60, 3'b001, 3'd5, 1'b0);
    push(b+72, 3'b101, 3'd0, 1'b1);

    // 2: load P=5 mid-step
    wait_cyc(b+76);
    do_load(5, t);
    push(b+84,  3'b100, 3'd1, 1'b0);
    push(b+104, 3'b110, 3'd2, 1'b0);
    push(b+124, 3'b010, 3'd3, 1'b0);

    // 3: reverse at index 3
    wait_cyc(b+130);
    bus.direction = 1'b0;
    push(b+144, 3'b110, 3'd2, 1'b0);
    push(b+164, 3'b100, 3'd1, 1'b0);
    push(b+184, 3'b101, 3'd0, 1'b0);
    push(b+204, 3'b001, 3'd5, 1'b1);

    // 4: P=1 clamps to 2, then load 0 stops after one more step
    wait_cyc(b+209);
    do_load(1, t);
    push(b+224, 3'b011, 3'd4, 1'b0);
    push(b+232, 3'b010, 3'd3, 1'b0);
    wait_cyc(b+234);
    do_load(0, t);
    push(b+240, 3'b110, 3'd2, 1'b0);
    wait_cyc(b+345);
    check("stop_hall", bus.hall, 3'b110);
    check("stop_index", bus.step_index, 3'd2);
    check("stop_step_pulse", bus.step_pulse, 1'b0);

    // 5: restart forward, pause 7 cycles mid-step, then reset mid-pulse
    bus.direction = 1'b1;
    wait_cyc(b+349);
    do_load(3, c);
    push(c+12, 3'b010, 3'd3, 1'b0);
    push(c+24, 3'b011, 3'd4, 1'b0);
    push(c+43, 3'b001, 3'd5, 1'b0);
    wait_cyc(c+28);
    bus.enable = 1'b0;
    wait_cyc(c+35);
    bus.enable = 1'b1;
    wait_cyc(c+43);
    #1 reset = 1'b0;
    #1;
    check("async_rst_hall", bus.hall, 3'b101);
    check("async_rst_index", bus.step_index, 3'd0);
    check("async_rst_step_pulse", bus.step_pulse, 1'b0);
    check("async_rst_rev_pulse", bus.rev_pulse, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // 6: load on the step cycle, then the longest period
    do_load(3, d);
    push(d+12, 3'b100, 3'd1, 1'b0);
    push(d+24, 3'b110, 3'd2, 1'b0);
    push(d+36, 3'b010, 3'd3, 1'b0);
    push(d+52, 3'b011, 3'd4, 1'b0);
    push(d+68, 3'b001, 3'd5, 1'b0);
    push(d+8256, 3'b101, 3'd0, 1'b1);
    wait_cyc(d+35);
    do_load(4, t);
    wait_cyc(d+54);
    do_load(2047, t);
    wait_cyc(d+8260);

    check("expectations_left", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hall_pattern_generator.md
Name: hall_pattern_generator

Overview:
- Hall-sensor emulator: emits the 3-bit, 6-step 120° commutation code at a commanded step period, in either direction.
- Transmit-side counterpart of the speed-measurement counter; uses the same 435-clock tick base so the measurement chain can be closed-loop tested on the FPGA without a motor.
- Also drives the commutation logic directly during bring-up.

Parameters:
- PERIOD_W, 11, width of the step-period value, in ticks.
- PRESCALE, 435, clock cycles per tick.
- MIN_PERIOD, 2, smallest non-zero period accepted; smaller non-zero values are clamped up to it.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = run; 0 = pause.
- direction  input  1  1 = forward, 0 = reverse; sampled only at a step.
- period_in  input  PERIOD_W  requested ticks per step; 0 = stop.
- period_load  input  1  one-cycle strobe; captures period_in.
- hall  output  3  current hall code {A,B,C}.
- step_index  output  3  current sequence index, 0..5.
- step_pulse  output  1  high for exactly 1 cycle, in the cycle hall changes.
- rev_pulse  output  1  high for 1 cycle on each electrical-revolution wrap.

Behaviour:
- Reset (reset=0, asynchronous):
  - hall=3'b101, step_index=0, step_pulse=0, rev_pulse=0.
  - Prescaler, tick counter, active_period and pending_period all cleared to 0.
- Sequence, index 0..5: 101, 100, 110, 010, 011, 001.
  - Forward: index+1 mod 6. Reverse: index-1 mod 6.
  - hall is always the registered decode of the index; it never shows an illegal code (000/111).
- Clamp function:
  - clamp(p) = 0 if p==0; MIN_PERIOD if 0<p<MIN_PERIOD; else p.
- Prescaler:
  - When enable=1 and active_period!=0: counts 0..PRESCALE-1, then wraps.
  - tick = (prescaler==PRESCALE-1) and counting.
- Tick counter:
  - Increments on tick.
  - A step fires when tick=1 and count==active_period-1. On a step, count goes to 0.
- Step cycle (registered; outputs visible the cycle after the terminal tick):
  - index advances in the direction sampled that cycle.
  - step_pulse=1.
  - rev_pulse=1 if index wraps 5->0 (forward) or 0->5 (reverse).
  - active_period <= clamp(period_in) if period_load is high in the same cycle (load wins); otherwise pending_period.
- Loading while running:
  - period_load with active_period!=0: pending_period <= clamp(period_in).
  - active_period is unchanged until the next step, so the current step always completes at the old rate.
- Loading while stopped:
  - period_load with active_period==0 and clamp(period_in)!=0: active_period and pending_period are loaded immediately; prescaler and count are cleared.
  - The first step occurs exactly P*PRESCALE cycles after the load cycle (enable=1 throughout).
- Stopping:
  - Loading 0 while running: the in-flight step completes, then active_period=0.
  - Once stopped: no further steps, hall holds, prescaler and count are held at 0.
- Pause:
  - enable=0 freezes prescaler, count and hall (no clearing); step_pulse and rev_pulse are forced to 0.
  - enable=1 resumes from the frozen state.
  - period_load is still accepted while paused.
- Steady-state timing:
  - step_pulse period = active_period*PRESCALE cycles.
  - rev_pulse period = 6*active_period*PRESCALE cycles.
- Direction change takes effect at the next step, with no glitch.
  - Example: at index 3 (010), switching forward->reverse gives next hall = 110.
- Width rules:
  - Tick counter is PERIOD_W bits wide; max period 2^PERIOD_W-1 must not overflow.
  - Prescaler width is ceil(log2(PRESCALE)).

Test Plan:
- Bench uses PRESCALE=4, MIN_PERIOD=2.
1. Reset release, load P=3 while stopped, direction=1 -> steps every 12 cycles; first step 12 cycles after load; hall sequence 100,110,010,011,001,101; rev_pulse on the 101 step (period 72 cycles).
2. Running at P=3, load P=5 mid-step -> current step completes at 12 cycles; following steps at 20 cycles; no short or long step at the change.
3. Toggle direction at index 3 -> next hall = 110 (index 2), then 100, 101; rev_pulse fires on the 101->001 wrap (0->5).
4. Load P=1 -> clamped to 2 (8 cycles per step). Load P=0 while running -> one more step, then hall frozen with step_pulse=0 for 100+ cycles.
5. Hold enable=0 for 7 cycles mid-step -> that step lands exactly 7 cycles late; no pulses during the pause. Assert reset mid-step -> hall=101 and all pulses 0 immediately, without waiting for a clock edge.
6. Assert period_load coincident with the step cycle (P=3 running, load 4) -> the next interval is already 16 cycles. With PERIOD_W=11, load P=2047 -> step after 8188 cycles, no counter overflow.
